instruction_fetch: RTL and testbench

Instruction prefetch unit sitting between the program counter, the memory bus and the instruction decoder in the gateboy CPU. It reads the PC value, fetches opcode bytes from memory into a small prefetch queue, and advances the PC through its count-enable. It also rewrites the PC through the PC's write port when the decoder requests a jump. It is the consumer of the PC's output and the sole driver of the PC's write and count controls.

---
 rtl/instruction_fetch.sv | 109 ++++++++++
 tb/tb_instruction_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction prefetch unit: fetches opcode bytes at the PC into a small queue for the decoder
// and owns the PC count/load controls, including decoder-requested absolute/relative jumps.
module instruction_fetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pcIn,
    output logic [15:0] pcDataOut,
    output logic        pcWriteEnable,
    output logic        pcCountEnable,
    output logic [15:0] memAddr,
    output logic        memRead,
    input  logic        memReady,
    input  logic [7:0]  memData,
    output logic        opValid,
    output logic [7:0]  opData,
    output logic [15:0] opAddr,
    input  logic        opReady,
    input  logic        jumpRequest,
    input  logic        jumpRelative,
    input  logic [15:0] jumpTarget
);
    // state | meaning
    // IDLE  | first cycle out of reset, no bus activity
    // REQ   | fetching bytes at pcIn while the queue has room
    // JUMP  | loading jumpReg into the PC, bus idle
    typedef enum logic [1:0] {IDLE, REQ, JUMP} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    state_t         state, stateNext;
    logic [PW:0]    count;
    logic [PW-1:0]  rdPtr, wrPtr;
    logic [15:0]    qAddr [DEPTH];
    logic [7:0]     qData [DEPTH];
    logic [15:0]    archPc, archPcNext, jumpReg, jumpCalc;
    logic           push, pop;

    assign opValid   = (count != '0);
    assign opAddr    = qAddr[rdPtr];
    assign opData    = qData[rdPtr];
    assign pop       = opValid & opReady;
    assign pcDataOut = jumpReg;

    // archPc as it stands after this cycle's pop, so a relative jump sees the popped byte
    assign archPcNext = pop ? opAddr + 16'd1 : archPc;
    assign jumpCalc   = jumpRelative ? archPcNext + jumpTarget : jumpTarget;

    always_comb begin
        stateNext     = state;
        memRead       = 1'b0;
        memAddr       = pcIn;
        push          = 1'b0;
        pcCountEnable = 1'b0;
        pcWriteEnable = 1'b0;
        case (state)
            IDLE: stateNext = REQ;
            REQ: begin
                memRead       = !reset & ((count < FULL) | pop);
                push          = memRead & memReady & !jumpRequest;
                pcCountEnable = push;
            end
            JUMP: begin
                stateNext     = REQ;
                pcWriteEnable = !reset;
            end
            default: stateNext = IDLE;
        endcase
        if (jumpRequest) stateNext = JUMP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            archPc  <= '0;
            jumpReg <= '0;
        end else begin
            state <= stateNext;
            if (jumpRequest) begin
                count   <= '0;
                rdPtr   <= '0;
                wrPtr   <= '0;
                jumpReg <= jumpCalc;
                archPc  <= jumpCalc;
            end else begin
                archPc <= archPcNext;
                if (push) wrPtr <= wrPtr + 1'b1;
                if (pop)  rdPtr <= rdPtr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qAddr[wrPtr] <= pcIn;
            qData[wrPtr] <= memData;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: models the PC and a zero-wait memory returning the low address
// byte; expected queue bytes go to a scoreboard checked by a monitor on every decoder pop.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pcIn, pcDataOut, memAddr, opAddr, jumpTarget;
    logic        pcWriteEnable, pcCountEnable, memRead, memReady, opValid, opReady;
    logic        jumpRequest, jumpRelative;
    logic [7:0]  memData, opData;

    logic        pcLoad = 1'b0;
    logic [15:0] pcLoadVal = 16'h0000;
    logic [15:0] pcReg;

    int nVec = 0;
    int nErr = 0;
    logic [23:0] expQ [$];

    instruction_fetch #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .pcIn(pcIn), .pcDataOut(pcDataOut),
        .pcWriteEnable(pcWriteEnable), .pcCountEnable(pcCountEnable),
        .memAddr(memAddr), .memRead(memRead), .memReady(memReady), .memData(memData),
        .opValid(opValid), .opData(opData), .opAddr(opAddr), .opReady(opReady),
        .jumpRequest(jumpRequest), .jumpRelative(jumpRelative), .jumpTarget(jumpTarget)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset)              pcReg <= 16'h0000;
        else if (pcLoad)        pcReg <= pcLoadVal;
        else if (pcWriteEnable) pcReg <= pcDataOut;
        else if (pcCountEnable) pcReg <= pcReg + 16'd1;
    end
    assign pcIn    = pcReg;
    assign memData = memAddr[7:0];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (pcWriteEnable || pcCountEnable)
                chk("pcStrobeExclusive", {15'd0, pcWriteEnable & pcCountEnable}, 16'd0);
            if (opValid && opReady) begin
                if (expQ.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("FAIL unexpectedPop: got opAddr %h, expected no pop", opAddr);
                end else begin
                    logic [23:0] e;
                    e = expQ.pop_front();
                    chk("popAddr", opAddr, e[23:8]);
                    chk("popData", {8'd0, opData}, {8'd0, e[7:0]});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic jumpTo(input logic rel, input logic [15:0] target);
        jumpRequest  = 1'b1;
        jumpRelative = rel;
        jumpTarget   = target;
        step();
        jumpRequest = 1'b0;
        expQ.delete();
    endtask

    task automatic fetchByte(input logic [15:0] addr);
        expQ.push_back({addr, addr[7:0]});
        memReady = 1'b1;
        step();
        memReady = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        memReady = 1'b1; opReady = 1'b0;
        jumpRequest = 1'b0; jumpRelative = 1'b0; jumpTarget = 16'h0000;

        // reset with memReady high
        step(); step();
        reset = 1'b0;
        settle();
        chk("rstOpValid", {15'd0, opValid}, 16'd0);
        chk("rstMemRead", {15'd0, memRead}, 16'd0);
        chk("rstPcWe", {15'd0, pcWriteEnable}, 16'd0);
        chk("rstPcDataOut", pcDataOut, 16'h0000);
        step(); settle();
        chk("firstMemRead", {15'd0, memRead}, 16'd1);
        chk("firstMemAddr", memAddr, 16'h0000);
        memReady = 1'b0;

        // zero-wait stream from 0x0100
        pcLoad = 1'b1; pcLoadVal = 16'h0100;
        step();
        pcLoad = 1'b0;
        for (int i = 0; i < 16; i++) expQ.push_back({16'h0100 + 16'(i), 8'(i)});
        opReady = 1'b1; memReady = 1'b1;
        repeat (16) step();
        memReady = 1'b0;
        settle();
        chk("streamPcEnd", pcIn, 16'h0110);
        step(); settle();
        chk("streamDrained", {15'd0, opValid}, 16'd0);

        // backpressure: queue fills to DEPTH
        opReady = 1'b0;
        for (int i = 0; i < 5; i++) expQ.push_back({16'h0110 + 16'(i), 8'h10 + 8'(i)});
        memReady = 1'b1;
        repeat (4) step();
        settle();
        chk("fullMemRead", {15'd0, memRead}, 16'd0);
        chk("fullPc", pcIn, 16'h0114);
        chk("fullHead", opAddr, 16'h0110);
        repeat (2) step();
        settle();
        chk("fullPcHeld", pcIn, 16'h0114);
        opReady = 1'b1;
        settle();
        chk("popMemRead", {15'd0, memRead}, 16'd1);
        step();
        opReady = 1'b0;
        settle();
        chk("oneMorePc", pcIn, 16'h0115);
        chk("refullMemRead", {15'd0, memRead}, 16'd0);

        // absolute jump while a read completes
        opReady = 1'b1;
        jumpTo(1'b0, 16'hDEAD);
        settle();
        chk("absFlush", {15'd0, opValid}, 16'd0);
        chk("absPcWe", {15'd0, pcWriteEnable}, 16'd1);
        chk("absPcData", pcDataOut, 16'hDEAD);
        chk("absNoCount", pcIn, 16'h0115);
        chk("absJumpMemRead", {15'd0, memRead}, 16'd0);
        expQ.push_back({16'hDEAD, 8'hAD});
        step(); settle();
        chk("absPcWeOnce", {15'd0, pcWriteEnable}, 16'd0);
        chk("absMemRead", {15'd0, memRead}, 16'd1);
        chk("absMemAddr", memAddr, 16'hDEAD);
        step();
        memReady = 1'b0;
        settle();
        chk("absOpValid", {15'd0, opValid}, 16'd1);
        chk("absOpAddr", opAddr, 16'hDEAD);
        step();

        // relative jump back by 5 from archPc 0x000D
        jumpTo(1'b0, 16'h000C);
        step();
        fetchByte(16'h000C);
        step();
        jumpTo(1'b1, 16'hFFFB);
        settle();
        chk("relPcWe", {15'd0, pcWriteEnable}, 16'd1);
        chk("relPcData", pcDataOut, 16'h0008);
        step(); settle();
        chk("relMemAddr", memAddr, 16'h0008);

        // relative jump wrapping past 0xFFFF
        jumpTo(1'b0, 16'hFFFE);
        step();
        fetchByte(16'hFFFE);
        step();
        jumpTo(1'b1, 16'h0002);
        settle();
        chk("wrapPcData", pcDataOut, 16'h0001);
        step();

        // jump in the same cycle as a pop, then retarget during JUMP
        opReady = 1'b0;
        jumpTo(1'b0, 16'h0010);
        step();
        fetchByte(16'h0010);
        settle();
        chk("popJumpHead", opAddr, 16'h0010);
        opReady = 1'b1;
        jumpTo(1'b1, 16'h0003);
        settle();
        chk("popJumpPcData", pcDataOut, 16'h0014);
        jumpTo(1'b0, 16'h1234);
        settle();
        chk("retargetPcWe", {15'd0, pcWriteEnable}, 16'd1);
        chk("retargetPcData", pcDataOut, 16'h1234);
        chk("retargetMemRead", {15'd0, memRead}, 16'd0);
        step(); settle();
        chk("retargetDone", {15'd0, pcWriteEnable}, 16'd0);
        chk("retargetMemAddr", memAddr, 16'h1234);
        chk("retargetPc", pcIn, 16'h1234);

        // reset with a byte queued and a read completing
        opReady = 1'b0;
        fetchByte(16'h1234);
        memReady = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        expQ.delete();
        settle();
        chk("midRstOpValid", {15'd0, opValid}, 16'd0);
        chk("midRstMemRead", {15'd0, memRead}, 16'd0);
        chk("midRstPcWe", {15'd0, pcWriteEnable}, 16'd0);
        step(); settle();
        chk("midRstMemAddr", memAddr, 16'h0000);
        chk("midRstReq", {15'd0, memRead}, 16'd1);
        memReady = 1'b0;
        step();

        chk("scoreboardEmpty", 16'(expQ.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
